phy_lane_sched: RTL and testbench

- Transmit-side scheduler that shares the PHY's single byte-wide path between the two 8-bit input lanes (lane 0, lane 1).
- Each lane is buffered in a small FIFO. Lanes are served round-robin at clk_2f, so two lanes at clk_f rate fill one clk_2f slot stream.
- A link FSM (IDLE/SYNC/ACTIVE) holds off traffic until a sync preamble of idle symbols has been sent.
- Sits between the lane sources and the PHY serializer (clk_8f domain, not part of this block).

---
 rtl/phy_lane_sched_if.sv | 27 ++
 rtl/phy_lane_sched.sv | 160 ++++++++++++++++
 tb/tb_phy_lane_sched.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/phy_lane_sched_if.sv
// Lane-side and PHY-side signal bundle for the two-lane transmit scheduler.
// Every lane handshake is valid/ready: a byte transfers on a rising edge where valid_in_x && ready_x.
interface phy_lane_sched_if;
  logic       enable;
  logic [7:0] data_in_0;
  logic       valid_in_0;
  logic       ready_0;
  logic [7:0] data_in_1;
  logic       valid_in_1;
  logic       ready_1;
  logic [7:0] data_out;
  logic       valid_out;
  logic       lane_out;
  logic [1:0] state_out;
  logic       err_0;
  logic       err_1;

  modport slave (
    input  enable, data_in_0, valid_in_0, data_in_1, valid_in_1,
    output ready_0, ready_1, data_out, valid_out, lane_out, state_out, err_0, err_1
  );

  modport master (
    output enable, data_in_0, valid_in_0, data_in_1, valid_in_1,
    input  ready_0, ready_1, data_out, valid_out, lane_out, state_out, err_0, err_1
  );
endinterface

// File: rtl/phy_lane_sched.sv
// Two-lane transmit scheduler: per-lane FIFOs, round-robin arbitration onto one byte path,
// gated by an IDLE/SYNC/ACTIVE link FSM that sends an idle-symbol preamble before traffic.
module phy_lane_sched #(
  parameter int         DEPTH       = 4,
  parameter int         SYNC_CYCLES = 4,
  parameter logic [7:0] IDLE_SYM    = 8'hBC
) (
  input logic             clk_2f,
  input logic             reset,
  phy_lane_sched_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(SYNC_CYCLES) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SYNC   = 2'b01,
    S_ACTIVE = 2'b10
  } state_t;

  logic [7:0]    r_mem  [2][DEPTH];
  logic [AW-1:0] r_wptr [2];
  logic [AW-1:0] r_rptr [2];
  logic [CW-1:0] r_cnt  [2];
  logic [1:0]    r_err;

  state_t        r_state, w_state_nxt;
  logic [SW-1:0] r_scnt, w_scnt_nxt;
  logic [7:0]    r_data, w_data_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_lane, w_lane_nxt;
  logic          r_last, w_last_nxt;

  logic [7:0]    w_din [2];
  logic [1:0]    w_vin, w_full, w_nempty, w_push, w_pop, w_ovf;
  logic          w_gnt, w_gnt_lane;

  assign w_din[0] = bus.data_in_0;
  assign w_din[1] = bus.data_in_1;
  assign w_vin    = {bus.valid_in_1, bus.valid_in_0};

  // A full FIFO rejects the write even when it is popped in the same cycle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_full[i]   = (r_cnt[i] == CW'(DEPTH));
      w_nempty[i] = (r_cnt[i] != '0);
      w_push[i]   = w_vin[i] && !w_full[i];
      w_ovf[i]    = w_vin[i] && w_full[i];
    end
  end

  assign w_pop[0] = w_gnt && !w_gnt_lane;
  assign w_pop[1] = w_gnt && w_gnt_lane;

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_err <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + 1'b1;
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + 1'b1;
        r_cnt[i] <= r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
        if (w_ovf[i])  r_err[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_2f) begin
    for (int i = 0; i < 2; i++) begin
      if (w_push[i]) r_mem[i][r_wptr[i]] <= w_din[i];
    end
  end

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_scnt  <= '0;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_lane  <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_scnt  <= w_scnt_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_lane  <= w_lane_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Output registers are loaded with the values belonging to the state being entered.
  always_comb begin
    w_state_nxt = r_state;
    w_scnt_nxt  = r_scnt;
    w_data_nxt  = 8'h00;
    w_valid_nxt = 1'b0;
    w_lane_nxt  = r_lane;
    w_last_nxt  = r_last;
    w_gnt       = 1'b0;
    w_gnt_lane  = r_last;
    case (r_state)
      S_IDLE: begin
        if (bus.enable) begin
          w_state_nxt = S_SYNC;
          w_scnt_nxt  = '0;
          w_data_nxt  = IDLE_SYM;
        end
      end
      S_SYNC: begin
        if (!bus.enable) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_scnt_nxt = r_scnt + 1'b1;
          w_data_nxt = IDLE_SYM;
          if (r_scnt == SW'(SYNC_CYCLES - 1)) w_state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (!bus.enable) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_data_nxt = IDLE_SYM;
          if (w_nempty[0] && w_nempty[1]) begin
            w_gnt      = 1'b1;
            w_gnt_lane = !r_last;
          end else if (w_nempty[0]) begin
            w_gnt      = 1'b1;
            w_gnt_lane = 1'b0;
          end else if (w_nempty[1]) begin
            w_gnt      = 1'b1;
            w_gnt_lane = 1'b1;
          end
          if (w_gnt) begin
            w_data_nxt  = r_mem[w_gnt_lane][r_rptr[w_gnt_lane]];
            w_valid_nxt = 1'b1;
            w_lane_nxt  = w_gnt_lane;
            w_last_nxt  = w_gnt_lane;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.ready_0   = !w_full[0];
  assign bus.ready_1   = !w_full[1];
  assign bus.data_out  = r_data;
  assign bus.valid_out = r_valid;
  assign bus.lane_out  = r_lane;
  assign bus.state_out = r_state;
  assign bus.err_0     = r_err[0];
  assign bus.err_1     = r_err[1];
endmodule

// File: tb/tb_phy_lane_sched.sv
// Directed bench for phy_lane_sched: scoreboard of {lane, byte} expected on the PHY side,
// plus direct checks of link state, idle symbols, ready and sticky overflow flags.
module tb_phy_lane_sched;
  logic clk_2f = 1'b0;
  logic reset  = 1'b1;

  phy_lane_sched_if bus ();

  phy_lane_sched #(
    .DEPTH       (4),
    .SYNC_CYCLES (4),
    .IDLE_SYM    (8'hBC)
  ) dut (
    .clk_2f (clk_2f),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_2f = ~clk_2f;

  logic [8:0] exp_q [$];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Any valid output byte must match the head of the expected queue.
  task automatic check_out();
    logic [8:0] e;
    if (bus.valid_out === 1'b1) begin
      n_cmp++;
      assert (exp_q.size() != 0)
      else begin
        n_err++;
        $error("FAIL unexpected_out observed=%0h expected=none", {bus.lane_out, bus.data_out});
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_lane_data", 32'({bus.lane_out, bus.data_out}), 32'(e));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_2f);
    #1;
    check_out();
  endtask

  task automatic sync_phase(input string tag);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk({tag, "_sync_state"}, 32'(bus.state_out), 32'h1);
      chk({tag, "_sync_data"},  32'(bus.data_out),  32'hBC);
      chk({tag, "_sync_valid"}, 32'(bus.valid_out), 32'h0);
    end
    tick();
    chk({tag, "_act_state"}, 32'(bus.state_out), 32'h2);
    chk({tag, "_act_data"},  32'(bus.data_out),  32'hBC);
    chk({tag, "_act_valid"}, 32'(bus.valid_out), 32'h0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    bus.enable     = 1'b0;
    bus.data_in_0  = 8'h00;
    bus.valid_in_0 = 1'b0;
    bus.data_in_1  = 8'h00;
    bus.valid_in_1 = 1'b0;

    // 1: reset state
    #12;
    chk("rst_data",  32'(bus.data_out),  32'h00);
    chk("rst_valid", 32'(bus.valid_out), 32'h0);
    chk("rst_lane",  32'(bus.lane_out),  32'h0);
    chk("rst_state", 32'(bus.state_out), 32'h0);
    chk("rst_ready", 32'({bus.ready_1, bus.ready_0}), 32'h3);
    chk("rst_err",   32'({bus.err_1, bus.err_0}),     32'h0);
    reset = 1'b0;
    tick();
    chk("idle_hold_state", 32'(bus.state_out), 32'h0);

    // 2: sync preamble with empty FIFOs
    bus.enable = 1'b1;
    sync_phase("p2");
    tick();
    chk("p2_empty_valid", 32'(bus.valid_out), 32'h0);

    // 3: back-to-back lane 0 stream in ACTIVE
    bus.data_in_0 = 8'hA1; bus.valid_in_0 = 1'b1; exp_q.push_back({1'b0, 8'hA1});
    tick();
    chk("p3_latency", 32'(bus.valid_out), 32'h0);
    bus.data_in_0 = 8'hA2; exp_q.push_back({1'b0, 8'hA2});
    tick();
    chk("p3_v1", 32'(bus.valid_out), 32'h1);
    bus.data_in_0 = 8'hA3; exp_q.push_back({1'b0, 8'hA3});
    tick();
    chk("p3_v2", 32'(bus.valid_out), 32'h1);
    bus.valid_in_0 = 1'b0;
    tick();
    chk("p3_v3", 32'(bus.valid_out), 32'h1);
    tick();
    chk("p3_idle_valid", 32'(bus.valid_out), 32'h0);
    chk("p3_idle_data",  32'(bus.data_out),  32'hBC);
    chk("p3_q_empty",    32'(exp_q.size()),  32'h0);

    // 4: preload both lanes in IDLE, then round-robin starting at lane 0
    bus.enable = 1'b0;
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      bus.data_in_0 = 8'h10 + 8'(i); bus.valid_in_0 = 1'b1;
      bus.data_in_1 = 8'h20 + 8'(i); bus.valid_in_1 = 1'b1;
      exp_q.push_back({1'b0, 8'h10 + 8'(i)});
      exp_q.push_back({1'b1, 8'h20 + 8'(i)});
      tick();
    end
    bus.valid_in_0 = 1'b0; bus.valid_in_1 = 1'b0;
    chk("p4_full_ready", 32'({bus.ready_1, bus.ready_0}), 32'h0);
    chk("p4_idle_state", 32'(bus.state_out), 32'h0);
    bus.enable = 1'b1;
    sync_phase("p4");
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("p4_valid", 32'(bus.valid_out), 32'h1);
    end
    tick();
    chk("p4_done_valid", 32'(bus.valid_out), 32'h0);
    chk("p4_q_empty",    32'(exp_q.size()),  32'h0);

    // 5: overflow on lane 1 in IDLE
    bus.enable = 1'b0;
    tick();
    chk("p5_idle_state", 32'(bus.state_out), 32'h0);
    chk("p5_idle_data",  32'(bus.data_out),  32'h00);
    for (int i = 0; i < 5; i++) begin
      bus.data_in_1 = 8'h30 + 8'(i); bus.valid_in_1 = 1'b1;
      if (i < 4) exp_q.push_back({1'b1, 8'h30 + 8'(i)});
      tick();
      if (i == 3) begin
        chk("p5_ready1_full", 32'(bus.ready_1), 32'h0);
        chk("p5_err1_pre",    32'(bus.err_1),   32'h0);
      end
    end
    chk("p5_err1_set", 32'(bus.err_1), 32'h1);
    bus.valid_in_1 = 1'b0;
    tick();
    chk("p5_err1_sticky", 32'(bus.err_1), 32'h1);
    chk("p5_err0_clear",  32'(bus.err_0), 32'h0);
    bus.enable = 1'b1;
    sync_phase("p5");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("p5_valid", 32'(bus.valid_out), 32'h1);
    end
    tick();
    chk("p5_no_dropped", 32'(bus.valid_out), 32'h0);
    chk("p5_err1_still", 32'(bus.err_1),     32'h1);
    chk("p5_q_empty",    32'(exp_q.size()),  32'h0);

    // 6a: disable mid-stream keeps remaining bytes for the next link-up
    bus.enable = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.data_in_0 = 8'h40 + 8'(i); bus.valid_in_0 = 1'b1;
      exp_q.push_back({1'b0, 8'h40 + 8'(i)});
      tick();
    end
    bus.valid_in_0 = 1'b0;
    bus.enable = 1'b1;
    sync_phase("p6a");
    tick();
    tick();
    chk("p6a_two_left", 32'(exp_q.size()), 32'h2);
    bus.enable = 1'b0;
    tick();
    chk("p6a_off_state", 32'(bus.state_out), 32'h0);
    chk("p6a_off_valid", 32'(bus.valid_out), 32'h0);
    chk("p6a_off_data",  32'(bus.data_out),  32'h00);
    tick();
    chk("p6a_off_hold", 32'(exp_q.size()), 32'h2);
    bus.enable = 1'b1;
    sync_phase("p6a_re");
    tick();
    chk("p6a_rem_v0", 32'(bus.valid_out), 32'h1);
    tick();
    chk("p6a_rem_v1", 32'(bus.valid_out), 32'h1);
    tick();
    chk("p6a_rem_done", 32'(bus.valid_out), 32'h0);
    chk("p6a_q_empty",  32'(exp_q.size()),  32'h0);

    // 6b: asynchronous reset mid-stream
    bus.enable = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.data_in_0 = 8'h60 + 8'(i); bus.valid_in_0 = 1'b1;
      exp_q.push_back({1'b0, 8'h60 + 8'(i)});
      tick();
    end
    bus.valid_in_0 = 1'b0;
    bus.enable = 1'b1;
    sync_phase("p6b");
    tick();
    chk("p6b_first_out", 32'(bus.valid_out), 32'h1);
    reset = 1'b1;
    #1;
    chk("p6b_rst_data",  32'(bus.data_out),  32'h00);
    chk("p6b_rst_valid", 32'(bus.valid_out), 32'h0);
    chk("p6b_rst_state", 32'(bus.state_out), 32'h0);
    chk("p6b_rst_ready", 32'({bus.ready_1, bus.ready_0}), 32'h3);
    chk("p6b_rst_err",   32'({bus.err_1, bus.err_0}),     32'h0);
    exp_q.delete();
    #1;
    reset = 1'b0;
    sync_phase("p6b_re");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("p6b_flushed", 32'(bus.valid_out), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
